// File: rtl/axi_pkg.sv
// Shared AXI write-channel definitions for the SRAM write slave:
// field widths, burst and response codes, and the write FSM states.
package axi_pkg;

    localparam int AXI_ID_W   = 8;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 4;
    localparam int AXI_SIZE_W = 3;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // The SRAM is one 32-bit word wide, so only 4-byte beats are legal.
    localparam logic [AXI_SIZE_W-1:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_e;

    // WRAP is treated as a plain increment; reserved codes hold the address.
    function automatic logic burstAdvances(input burst_e burst);
        return (burst == INCR) || (burst == WRAP);
    endfunction

endpackage

// File: rtl/wr_addr_gen.sv
// Word-address register for the SRAM write slave: loaded at the AW
// handshake and stepped once per accepted W beat according to the burst type.
module wr_addr_gen
    import axi_pkg::*;
#(
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [SRAM_AW-1:0] start_addr_i,
    input  logic [1:0]         burst_i,
    input  logic               step_i,
    output logic [SRAM_AW-1:0] addr_o
);

    localparam logic [SRAM_AW-1:0] ONE = {{(SRAM_AW-1){1'b0}}, 1'b1};

    logic [SRAM_AW-1:0] addr_q, addr_d;
    burst_e             burst_q, burst_d;

    always_comb begin
        addr_d  = addr_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = start_addr_i;
            burst_d = burst_e'(burst_i);
        end else if (step_i && burstAdvances(burst_q)) begin
            // Natural overflow gives the modulo-2^SRAM_AW wrap.
            addr_d = addr_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            burst_q <= FIXED;
        end else begin
            addr_q  <= addr_d;
            burst_q <= burst_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sram_wr_slave.sv
// AXI write slave that turns AW/W/B bursts into single-cycle SRAM writes.
// Optional macro WR_ERR_CHECK_EN enables SLVERR reporting for size/length errors.
module sram_wr_slave
    import axi_pkg::*;
#(
    parameter int SRAM_AW = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ID_W-1:0]   AWID_S,
    input  logic [AXI_ADDR_W-1:0] AWADDR_S,
    input  logic [AXI_LEN_W-1:0]  AWLEN_S,
    input  logic [AXI_SIZE_W-1:0] AWSIZE_S,
    input  logic [1:0]            AWBURST_S,
    input  logic                  AWVALID_S,
    output logic                  AWREADY_S,
    input  logic [AXI_DATA_W-1:0] WDATA_S,
    input  logic [AXI_STRB_W-1:0] WSTRB_S,
    input  logic                  WLAST_S,
    input  logic                  WVALID_S,
    output logic                  WREADY_S,
    output logic [AXI_ID_W-1:0]   BID_S,
    output logic [1:0]            BRESP_S,
    output logic                  BVALID_S,
    input  logic                  BREADY_S,
    output logic                  sram_ceb,
    output logic [AXI_STRB_W-1:0] sram_web,
    output logic [SRAM_AW-1:0]    sram_a,
    output logic [AXI_DATA_W-1:0] sram_di
);

    wr_state_e             state_q, state_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic [AXI_LEN_W-1:0]  beatCnt_q, beatCnt_d;

    logic awFire;
    logic wFire;
    logic bFire;
    logic lenReached;
    logic lastBeat;

    assign awFire     = AWVALID_S && AWREADY_S;
    assign wFire      = WVALID_S && WREADY_S;
    assign bFire      = BVALID_S && BREADY_S;
    assign lenReached = (beatCnt_q == len_q);
    assign lastBeat   = WLAST_S || lenReached;

    // AWREADY is gated by rst so it reads low for the whole reset pulse.
    always_comb begin
        state_d   = state_q;
        AWREADY_S = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        case (state_q)
            IDLE: begin
                AWREADY_S = rst;
                if (AWVALID_S && rst) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                WREADY_S = 1'b1;
                if (WVALID_S && lastBeat) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                BVALID_S = 1'b1;
                if (BREADY_S) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        id_d      = id_q;
        len_d     = len_q;
        beatCnt_d = beatCnt_q;
        if (awFire) begin
            id_d      = AWID_S;
            len_d     = AWLEN_S;
            beatCnt_d = '0;
        end else if (wFire) begin
            beatCnt_d = beatCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beatCnt_q <= beatCnt_d;
        end
    end

`ifdef WR_ERR_CHECK_EN
    logic       errFlag_q, errFlag_d;
    logic [1:0] resp_q, resp_d;
    logic       beatErr;

    // A beat is in error when WLAST and the AWLEN count disagree about where the burst ends.
    assign beatErr = (WLAST_S != lenReached);

    always_comb begin
        errFlag_d = errFlag_q;
        resp_d    = resp_q;
        if (awFire) begin
            errFlag_d = (AWSIZE_S != SIZE_WORD);
        end else if (wFire) begin
            errFlag_d = errFlag_q || beatErr;
            if (lastBeat) begin
                resp_d = (errFlag_q || beatErr) ? SLVERR : OKAY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errFlag_q <= 1'b0;
            resp_q    <= OKAY;
        end else begin
            errFlag_q <= errFlag_d;
            resp_q    <= resp_d;
        end
    end

    assign BRESP_S = resp_q;

    logic unusedBits;
    assign unusedBits = ^{AWADDR_S[AXI_ADDR_W-1:SRAM_AW+2], AWADDR_S[1:0], bFire};
`else
    assign BRESP_S = OKAY;

    logic unusedBits;
    assign unusedBits = ^{AWADDR_S[AXI_ADDR_W-1:SRAM_AW+2], AWADDR_S[1:0], AWSIZE_S, bFire};
`endif

    wr_addr_gen #(
        .SRAM_AW (SRAM_AW)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load_i       (awFire),
        .start_addr_i (AWADDR_S[SRAM_AW+1:2]),
        .burst_i      (AWBURST_S),
        .step_i       (wFire),
        .addr_o       (sram_a)
    );

    assign BID_S    = id_q;
    assign sram_ceb = ~wFire;
    assign sram_web = wFire ? ~WSTRB_S : {AXI_STRB_W{1'b1}};
    assign sram_di  = wFire ? WDATA_S : '0;

endmodule

// File: tb/tb_sram_wr_slave.sv
// Scoreboard bench for sram_wr_slave: expected SRAM writes and B responses are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_sram_wr_slave;

    localparam int AW = 14;

    logic          clk;
    logic          rst;
    logic [7:0]    AWID_S;
    logic [31:0]   AWADDR_S;
    logic [3:0]    AWLEN_S;
    logic [2:0]    AWSIZE_S;
    logic [1:0]    AWBURST_S;
    logic          AWVALID_S;
    logic          AWREADY_S;
    logic [31:0]   WDATA_S;
    logic [3:0]    WSTRB_S;
    logic          WLAST_S;
    logic          WVALID_S;
    logic          WREADY_S;
    logic [7:0]    BID_S;
    logic [1:0]    BRESP_S;
    logic          BVALID_S;
    logic          BREADY_S;
    logic          sram_ceb;
    logic [3:0]    sram_web;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_di;

    sram_wr_slave #(.SRAM_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .AWID_S    (AWID_S),
        .AWADDR_S  (AWADDR_S),
        .AWLEN_S   (AWLEN_S),
        .AWSIZE_S  (AWSIZE_S),
        .AWBURST_S (AWBURST_S),
        .AWVALID_S (AWVALID_S),
        .AWREADY_S (AWREADY_S),
        .WDATA_S   (WDATA_S),
        .WSTRB_S   (WSTRB_S),
        .WLAST_S   (WLAST_S),
        .WVALID_S  (WVALID_S),
        .WREADY_S  (WREADY_S),
        .BID_S     (BID_S),
        .BRESP_S   (BRESP_S),
        .BVALID_S  (BVALID_S),
        .BREADY_S  (BREADY_S),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_di   (sram_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    web;
        logic [31:0]   di;
    } wrExp_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } bExp_t;

    wrExp_t wrQ[$];
    bExp_t  bQ[$];
    wrExp_t eW;
    bExp_t  eB;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor samples mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (rst && !sram_ceb) begin
            if (wrQ.size() == 0) begin
                checkOutput("unexp_write_ceb", 32'(sram_ceb), 32'd1);
            end else begin
                eW = wrQ.pop_front();
                checkOutput("sram_a", 32'(sram_a), 32'(eW.a));
                checkOutput("sram_web", 32'(sram_web), 32'(eW.web));
                checkOutput("sram_di", sram_di, eW.di);
            end
        end
        if (rst && BVALID_S && BREADY_S) begin
            if (bQ.size() == 0) begin
                checkOutput("unexp_bvalid", 32'(BVALID_S), 32'd0);
            end else begin
                eB = bQ.pop_front();
                checkOutput("bid", 32'(BID_S), 32'(eB.id));
                checkOutput("bresp", 32'(BRESP_S), 32'(eB.resp));
            end
        end
    end

    task automatic doAw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output logic ok);
        int n = 0;
        AWID_S    = id;
        AWADDR_S  = addr;
        AWLEN_S   = len;
        AWSIZE_S  = size;
        AWBURST_S = burst;
        AWVALID_S = 1'b1;
        @(negedge clk);
        while (!AWREADY_S && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!AWREADY_S) begin
            checkOutput("aw_timeout", 32'(AWREADY_S), 32'd1);
            AWVALID_S = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        AWVALID_S = 1'b0;
        checkOutput("wready_lat", 32'(WREADY_S), 32'd1);
        checkOutput("awready_in_data", 32'(AWREADY_S), 32'd0);
        ok = 1'b1;
    endtask

    task automatic doW(input logic [31:0] data, input logic [3:0] strb, input logic last, output logic ok);
        int n = 0;
        WDATA_S  = data;
        WSTRB_S  = strb;
        WLAST_S  = last;
        WVALID_S = 1'b1;
        @(negedge clk);
        while (!WREADY_S && n < 20) begin
            n++;
            @(negedge clk);
        end
        ok = WREADY_S;
        if (!WREADY_S) begin
            checkOutput("w_timeout", 32'(WREADY_S), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        WVALID_S = 1'b0;
        WLAST_S  = 1'b0;
    endtask

    task automatic recvB(input int hold, input logic [1:0] expResp);
        int n = 0;
        BREADY_S = 1'b0;
        @(negedge clk);
        while (!BVALID_S && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!BVALID_S) begin
            checkOutput("b_timeout", 32'(BVALID_S), 32'd1);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            checkOutput("bvalid_hold", 32'(BVALID_S), 32'd1);
            checkOutput("bresp_hold", 32'(BRESP_S), 32'(expResp));
            checkOutput("awready_in_resp", 32'(AWREADY_S), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        BREADY_S = 1'b1;
        @(posedge clk);
        #1;
        BREADY_S = 1'b0;
        checkOutput("awready_back", 32'(AWREADY_S), 32'd1);
        checkOutput("bvalid_drop", 32'(BVALID_S), 32'd0);
    endtask

    // One full burst: AW, beats up to WLAST or AWLEN, then the B response.
    task automatic applyStimulus(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input int lastIdx,
                                 input logic [3:0] strb, input int hold);
        logic          ok;
        logic [AW-1:0] a;
        logic [31:0]   data;
        logic [1:0]    expResp;
        int            nBeats;
        a       = addr[AW+1:2];
        nBeats  = (lastIdx < int'(len)) ? lastIdx + 1 : int'(len) + 1;
        expResp = 2'b00;
`ifdef WR_ERR_CHECK_EN
        if (size != 3'b010 || lastIdx != int'(len)) expResp = 2'b10;
`endif
        doAw(id, addr, len, size, burst, ok);
        if (!ok) return;
        for (int i = 0; i < nBeats; i++) begin
            data = $urandom();
            wrQ.push_back('{a, ~strb, data});
            doW(data, strb, (i == lastIdx), ok);
            if (!ok) return;
            if (burst != 2'b00) a = a + 1'b1;
        end
        checkOutput("bvalid_lat", 32'(BVALID_S), 32'd1);
        checkOutput("wready_in_resp", 32'(WREADY_S), 32'd0);
        bQ.push_back('{id, expResp});
        recvB(hold, expResp);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic ok;
        logic [3:0] rlen;
        rst       = 1'b0;
        AWID_S    = '0;
        AWADDR_S  = '0;
        AWLEN_S   = '0;
        AWSIZE_S  = '0;
        AWBURST_S = '0;
        AWVALID_S = 1'b0;
        WDATA_S   = '0;
        WSTRB_S   = '0;
        WLAST_S   = 1'b0;
        WVALID_S  = 1'b0;
        BREADY_S  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_awready", 32'(AWREADY_S), 32'd0);
        checkOutput("rst_wready", 32'(WREADY_S), 32'd0);
        checkOutput("rst_bvalid", 32'(BVALID_S), 32'd0);
        checkOutput("rst_bid", 32'(BID_S), 32'd0);
        checkOutput("rst_bresp", 32'(BRESP_S), 32'd0);
        checkOutput("rst_ceb", 32'(sram_ceb), 32'd1);
        checkOutput("rst_web", 32'(sram_web), 32'hF);
        checkOutput("rst_a", 32'(sram_a), 32'd0);
        checkOutput("rst_di", sram_di, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("awready_after_rst", 32'(AWREADY_S), 32'd1);

        applyStimulus(8'h15, 32'h0000_0010, 4'd3, 3'b010, 2'b01, 3, 4'hF, 0);
        applyStimulus(8'h22, 32'h0000_0020, 4'd1, 3'b010, 2'b00, 1, 4'hF, 0);
        applyStimulus(8'h33, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01, 1, 4'hF, 1);
        applyStimulus(8'h44, 32'h0000_0100, 4'd2, 3'b010, 2'b10, 2, 4'b0101, 5);

        // W beats while idle must be ignored.
        WDATA_S  = 32'hDEAD_BEEF;
        WSTRB_S  = 4'hF;
        WVALID_S = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_wready", 32'(WREADY_S), 32'd0);
            checkOutput("idle_ceb", 32'(sram_ceb), 32'd1);
        end
        @(posedge clk);
        #1;
        WVALID_S = 1'b0;

        applyStimulus(8'h55, 32'h0000_0200, 4'd3, 3'b010, 2'b01, 1, 4'hF, 2);
        applyStimulus(8'h66, 32'h0000_0300, 4'd1, 3'b010, 2'b01, 5, 4'hF, 0);
        applyStimulus(8'h77, 32'h0000_0400, 4'd0, 3'b001, 2'b01, 0, 4'hF, 0);
        applyStimulus(8'h88, 32'h0000_0500, 4'd1, 3'b010, 2'b01, 1, 4'h0, 0);

        for (int r = 0; r < 4; r++) begin
            rlen = 4'($urandom_range(0, 7));
            applyStimulus(8'($urandom()), $urandom(), rlen, 3'b010, 2'($urandom_range(0, 2)),
                          int'(rlen), 4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a 4-beat burst aborts it without a response.
        doAw(8'h99, 32'h0000_0600, 4'd3, 3'b010, 2'b01, ok);
        if (ok) begin
            wrQ.push_back('{14'h180, 4'h0, 32'h1234_5678});
            doW(32'h1234_5678, 4'hF, 1'b0, ok);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_awready", 32'(AWREADY_S), 32'd0);
        checkOutput("mid_rst_wready", 32'(WREADY_S), 32'd0);
        checkOutput("mid_rst_bvalid", 32'(BVALID_S), 32'd0);
        checkOutput("mid_rst_bid", 32'(BID_S), 32'd0);
        checkOutput("mid_rst_ceb", 32'(sram_ceb), 32'd1);
        checkOutput("mid_rst_web", 32'(sram_web), 32'hF);
        checkOutput("mid_rst_a", 32'(sram_a), 32'd0);
        checkOutput("mid_rst_di", sram_di, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_rst_awready", 32'(AWREADY_S), 32'd1);
            checkOutput("post_rst_bvalid", 32'(BVALID_S), 32'd0);
        end

        checkOutput("wr_queue_left", 32'(wrQ.size()), 32'd0);
        checkOutput("b_queue_left", 32'(bQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_wr_slave.md
SRAM_WR_SLAVE -- requirements
Module: sram_wr_slave

Interface
REQ-001 Parameter: SRAM_AW, 14, SRAM word-address width.
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 AWID_S  input  8  write-address ID.
REQ-005 AWADDR_S  input  32  byte address.
REQ-006 AWLEN_S  input  4  beats minus one.
REQ-007 AWSIZE_S  input  3  beat size code.
REQ-008 AWBURST_S  input  2  burst type.
REQ-009 AWVALID_S  input  1 / AWREADY_S  output  1  AW handshake.
REQ-010 WDATA_S  input  32  write data.
REQ-011 WSTRB_S  input  4  byte strobes.
REQ-012 WLAST_S  input  1  last beat.
REQ-013 WVALID_S  input  1 / WREADY_S  output  1  W handshake.
REQ-014 BID_S  output  8  response ID.
REQ-015 BRESP_S  output  2  response code.
REQ-016 BVALID_S  output  1 / BREADY_S  input  1  B handshake.
REQ-017 sram_ceb  output  1  chip enable, active-low.
REQ-018 sram_web  output  4  per-byte write enable, active-low.
REQ-019 sram_a  output  SRAM_AW  word address.
REQ-020 sram_di  output  32  write data.

Function
REQ-021 FSM states: IDLE, DATA, RESP; IDLE is the reset state.
- IDLE: AWREADY_S=1 and WREADY_S=0.
- On AWVALID_S&&AWREADY_S: capture AWID_S, AWADDR_S[SRAM_AW+1:2], AWLEN_S and AWBURST_S; clear the beat counter; next state DATA.
REQ-022 DATA: WREADY_S=1 and AWREADY_S=0.
- A W handshake drives sram_ceb=0, sram_web=~WSTRB_S, sram_a=current address and sram_di=WDATA_S combinationally in the same cycle.
- With no handshake: sram_ceb=1, sram_web=4'hF.
REQ-023 Address update after each beat:
- INCR (01) and WRAP (10): address +1, modulo 2^SRAM_AW.
- FIXED (00): address unchanged.
REQ-024 Beat counter increments per W handshake. DATA exits to RESP after the handshake where WLAST_S=1 or count==AWLEN_S, whichever occurs first.
REQ-025 RESP: BVALID_S=1 and BID_S=captured ID; BRESP_S held stable until BREADY_S. On BVALID_S&&BREADY_S the next state is IDLE.
REQ-026 Latency:
- WREADY_S asserts the cycle after the AW handshake.
- BVALID_S asserts the cycle after the last W handshake.
- AWREADY_S reasserts the cycle after the B handshake.
REQ-027 W beats presented in IDLE or RESP are not accepted (WREADY_S=0) and cause no SRAM access.
REQ-028 A beat with WSTRB_S=4'h0 still counts, with sram_web=4'hF.

Reset
REQ-029 While rst=0:
- FSM=IDLE; AWREADY_S=0 during reset, 1 after release.
- WREADY_S=0, BVALID_S=0, BID_S=0, BRESP_S=2'b00.
- sram_ceb=1, sram_web=4'hF, sram_a=0, sram_di=0.
REQ-030 Reset asserted mid-burst or mid-response aborts the transaction; no B response is issued for it.

Configuration
REQ-031 Macro WR_ERR_CHECK_EN:
- Defined: BRESP_S=SLVERR (2'b10) if AWSIZE_S!=3'b010 was captured, or if WLAST_S position disagrees with AWLEN_S (early WLAST, or count==AWLEN_S without WLAST); otherwise OKAY (2'b00). The SRAM writes occur regardless.
- Undefined: BRESP_S is always 2'b00 and no size or length is captured for checking.

Structure
REQ-032 Shared package axi_pkg holds:
- width constants: ID 8, ADDR 32, LEN 4, SIZE 3, DATA 32, STRB 4;
- burst enum: FIXED, INCR, WRAP;
- resp constants: OKAY, SLVERR;
- FSM state enum.
REQ-033 One sub-module, wr_addr_gen, holds the address register and burst increment logic. There are no other sub-modules.

Verification
REQ-034 AWADDR=0x0000_0010, AWLEN=3, INCR, AWID=0x15, four beats with WSTRB=F -> sram_a=4,5,6,7; BID=0x15; BRESP=00.
REQ-035 FIXED burst at AWADDR=0x20, AWLEN=1 -> both writes use sram_a=8.
REQ-036 AWADDR=0x0000_FFFC with SRAM_AW=14, AWLEN=1, INCR -> sram_a=0x3FFF then 0x0000.
REQ-037 WSTRB=4'b0101 -> sram_web=4'b1010; BREADY held low 5 cycles -> BVALID and BRESP stable, AWREADY stays 0.
REQ-038 WR_ERR_CHECK_EN defined, AWLEN=3, WLAST on beat 2 -> RESP after 2 writes, BRESP=10.
REQ-039 rst pulled low after beat 1 of a 4-beat burst -> all outputs at reset values; after release AWREADY=1 and no BVALID.
